mult_rr_arbiter: RTL and testbench

Shares one sequential 8x8 shift-add multiply engine between NREQ requesters. Arbitration is fair round-robin, and each requester uses a valid/ready handshake. The block accepts one request and runs the engine for eight cycles. It then returns the 16-bit product tagged with the winning requester's index. It sits between the requesting datapath blocks and the multiply resource, so no requester needs its own multiplier.

---
 rtl/mult_rr_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mult_rr_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_rr_arbiter.sv
// mult_rr_arbiter: round-robin arbiter in front of one shared sequential
// 8x8 shift-add multiplier. One request is accepted at a time. The product is
// returned with the index of the requester that won.
// Optional build macro: MULT_ARB_ZERO_SKIP_EN. When it is defined, a request
// with a zero operand bypasses the eight RUN cycles and completes at once.
module mult_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_a,
    input  logic [8*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [15:0]         rsp_prod,
    output logic [IDW-1:0]      rsp_id,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_reg, state_next;
    logic [IDW-1:0]  ptr_reg;
    logic [15:0]     num_reg;
    logic [7:0]      mul_reg;
    logic [15:0]     acc_reg;
    logic [3:0]      count_reg;
    logic [IDW-1:0]  id_reg;       // owner of the operation in flight
    logic [15:0]     prod_reg;     // presented product, held until next DONE
    logic [IDW-1:0]  rsp_id_reg;   // presented owner, held until next DONE

    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [IDW:0]    cand;
    logic [NREQ-1:0] grant_onehot;
    logic [7:0]      grant_a;
    logic [7:0]      grant_b;
    logic [IDW-1:0]  ptr_after;
    logic [15:0]     acc_sum;
    logic            skip;

    // Round-robin search: first valid requester at or above ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_reg} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!grant_found && req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign grant_onehot[gi] = grant_found && (grant_idx == IDW'(gi));
        end
    endgenerate

    assign grant_a   = req_a[{grant_idx, 3'b000} +: 8];
    assign grant_b   = req_b[{grant_idx, 3'b000} +: 8];
    assign ptr_after = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    assign acc_sum   = acc_reg + (mul_reg[0] ? num_reg : 16'd0);

`ifdef MULT_ARB_ZERO_SKIP_EN
    assign skip = (grant_a == 8'd0) || (grant_b == 8'd0);
`else
    assign skip = 1'b0;
`endif

    // Grants only exist in IDLE, and are suppressed while reset is held.
    assign req_ready = (state_reg == IDLE && reset) ? grant_onehot : '0;
    assign rsp_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign rsp_prod  = prod_reg;
    assign rsp_id    = rsp_id_reg;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    state_next = skip ? DONE : RUN;
                end
            end
            RUN: begin
                if (count_reg == 4'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add steps and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_reg    <= '0;
            num_reg    <= '0;
            mul_reg    <= '0;
            acc_reg    <= '0;
            count_reg  <= '0;
            id_reg     <= '0;
            prod_reg   <= '0;
            rsp_id_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        num_reg   <= {8'd0, grant_a};
                        mul_reg   <= grant_b;
                        acc_reg   <= '0;
                        count_reg <= 4'd8;
                        id_reg    <= grant_idx;
                        ptr_reg   <= ptr_after;
                        if (skip) begin
                            prod_reg   <= '0;
                            rsp_id_reg <= grant_idx;
                        end
                    end
                end
                RUN: begin
                    acc_reg   <= acc_sum;
                    num_reg   <= num_reg << 1;
                    mul_reg   <= mul_reg >> 1;
                    count_reg <= count_reg - 4'd1;
                    if (count_reg == 4'd1) begin
                        prod_reg   <= acc_sum;
                        rsp_id_reg <= id_reg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Testbench for mult_rr_arbiter: table of single requests, then fairness,
// backpressure and reset-abort sequences. Expected responses go into a
// scoreboard queue at grant time and are popped by a response monitor.
module tb_mult_rr_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [8*NREQ-1:0]   req_a = '0;
    logic [8*NREQ-1:0]   req_b = '0;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic                rsp_ready = 1'b1;
    logic [15:0]         rsp_prod;
    logic [IDW-1:0]      rsp_id;
    logic                busy;

    mult_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_prod  (rsp_prod),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
    } vec_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [15:0]    prod;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Response monitor: every completed response handshake pops one expectation.
    always @(negedge clk) begin
        if (reset) begin
            check("req_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual id=%0d prod=%0d required no response",
                             rsp_id, rsp_prod);
                end else begin
                    mon_e = sb.pop_front();
                    $display("rsp id=%0d prod=%0d (expected id=%0d prod=%0d)",
                             rsp_id, rsp_prod, mon_e.id, mon_e.prod);
                    check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                    check("rsp_prod", 32'(rsp_prod), 32'(mon_e.prod));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b);
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
    endtask

    // Waits (bounded) for a grant, sampling on the falling edge.
    task automatic wait_grant(output int idx);
        idx = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ready[i]) idx = i;
                end
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL grant_timeout actual=none required=a grant within 40 cycles");
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && sb.size() != 0; n++) tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    // Edges after the accept edge until rsp_valid is seen. Without zero-skip
    // the eighth RUN edge raises it; with zero-skip a zero operand shows it
    // directly after the accept edge.
    function automatic int lat_for(input vec_t v);
`ifdef MULT_ARB_ZERO_SKIP_EN
        return (v.a == 8'd0 || v.b == 8'd0) ? 0 : 8;
`else
        return 8;
`endif
    endfunction

    task automatic send(input vec_t v);
        int g;
        int lat;
        set_ops(v.id, v.a, v.b);
        req_valid = NREQ'(1) << v.id;
        wait_grant(g);
        check("grant_id", 32'(g), 32'(v.id));
        if (g < 0) begin
            req_valid = '0;
            return;
        end
        sb.push_back({IDW'(v.id), v.prod});
        tick();
        req_valid = '0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        $display("req id=%0d a=%0d b=%0d latency=%0d", v.id, v.a, v.b, lat);
        check("latency", 32'(lat), 32'(lat_for(v)));
        tick();
        check("busy_after_rsp", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
    endtask

    vec_t vecs[8];
    int   g;
    int   n;
    int   cyc;
    int   last;
    int   lat;
    logic seen;

    initial begin
        vecs[0] = '{2, 8'd13,  8'd11, 16'd143};
        vecs[1] = '{0, 8'd255, 8'd255, 16'd65025};
        vecs[2] = '{1, 8'd128, 8'd2,  16'd256};
        vecs[3] = '{3, 8'd0,   8'd77, 16'd0};
        vecs[4] = '{1, 8'd77,  8'd0,  16'd0};
        vecs[5] = '{0, 8'd1,   8'd1,  16'd1};
        vecs[6] = '{3, 8'd200, 8'd3,  16'd600};
        vecs[7] = '{2, 8'd17,  8'd15, 16'd255};

        // Reset state, observed while reset is still asserted.
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_prod", 32'(rsp_prod), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) send(vecs[i]);

        // Fairness: everyone requesting, grants must rotate 0,1,2,3,0 every 10 cycles.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_ops(i, 8'(10 + i), 8'(3 + i));
        req_valid = '1;
        n = 0;
        cyc = 0;
        last = 0;
        while (n < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (req_ready != '0) begin
                g = -1;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
                $display("grant id=%0d cycle=%0d", g, cyc);
                check("rr_order", 32'(g), 32'(n % NREQ));
                if (n > 0) check("grant_spacing", 32'(cyc - last), 32'd10);
                last = cyc;
                sb.push_back({IDW'(g), 16'((10 + g) * (3 + g))});
                n++;
            end
        end
        check("fair_grant_count", 32'(n), 32'd5);
        tick();
        req_valid = '0;
        drain();

        // Backpressure: pointer now sits at 1; stall 20 cycles in DONE.
        rsp_ready = 1'b0;
        req_valid = '1;
        wait_grant(g);
        check("bp_grant", 32'(g), 32'd1);
        sb.push_back({IDW'(1), 16'd44});
        tick();
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd8);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_prod", 32'(rsp_prod), 32'd44);
            check("bp_rsp_id", 32'(rsp_id), 32'd1);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_grant(g);
        check("bp_next_grant", 32'(g), 32'd2);
        sb.push_back({IDW'(2), 16'd60});
        tick();
        req_valid = '0;
        drain();

        // Reset in the middle of RUN: requester 1 accepted, then aborted.
        req_valid = 4'b0010;
        wait_grant(g);
        check("abort_grant", 32'(g), 32'd1);
        tick();
        req_valid = '0;
        repeat (4) tick();
        reset = 1'b0;
        req_valid = 4'b0100;
        #1;
        check("abort_req_ready", 32'(req_ready), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_rsp_prod", 32'(rsp_prod), 32'd0);
        check("abort_rsp_id", 32'(rsp_id), 32'd0);
        tick();
        tick();
        req_valid = '0;
        reset = 1'b1;
        sb.delete();
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("abort_no_rsp", 32'(seen), 32'd0);
        @(posedge clk);
        #1;
        req_valid = '1;
        wait_grant(g);
        check("post_reset_ptr_grant", 32'(g), 32'd0);
        sb.push_back({IDW'(0), 16'd30});
        tick();
        req_valid = '0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
